// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Signed support is compiled in only when SEQ_MUL_SIGNED_EN is defined.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // The counter must be able to hold WIDTH itself, not just WIDTH-1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_mul_addsub.sv
// (WIDTH+1)-bit adder for one multiplier step; the subtract path and sign
// extension exist only when SEQ_MUL_SIGNED_EN is defined.
module seq_mul_addsub
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] mcand,
   input  logic             add_en,
`ifdef SEQ_MUL_SIGNED_EN
   input  logic             sgn,
   input  logic             sub,
`endif
   output logic [WIDTH:0]   sum
);

`ifdef SEQ_MUL_SIGNED_EN
   logic [WIDTH:0] hi_ext;
   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] addend;
   logic           cin;

   assign hi_ext = {sgn & hi[WIDTH-1], hi};
   assign m_ext  = {sgn & mcand[WIDTH-1], mcand};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      addend = '0;
      cin    = 1'b0;
      if (add_en) begin
         addend = sub ? ~m_ext : m_ext;
         cin    = sub;
      end
   end

   assign sum = hi_ext + addend + {{WIDTH{1'b0}}, cin};
`else
   logic [WIDTH:0] addend;

   always_comb begin
      addend = '0;
      if (add_en) addend = {1'b0, mcand};
   end

   assign sum = {1'b0, hi} + addend;
`endif

endmodule

// File: rtl/seq_mul_param.sv
// Sequential shift-add multiplier, one multiplier bit per clock, LSB first.
// Define SEQ_MUL_SIGNED_EN to enable two's-complement operation via sgn.
module seq_mul_param
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   op
);

   localparam int CW = cnt_width(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("seq_mul_param: WIDTH must lie in 2..32");
   end

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mult;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     sum;
   logic               last;

   assign last = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MUL_SIGNED_EN
   logic sgn_q;

   // The final multiplier bit carries negative weight in two's complement.
   seq_mul_addsub #(.WIDTH(WIDTH)) u_addsub (
      .hi     (acc[2*WIDTH-1:WIDTH]),
      .mcand  (mcand),
      .add_en (mult[0]),
      .sgn    (sgn_q),
      .sub    (sgn_q & last),
      .sum    (sum)
   );
`else
   logic sgn_unused;
   assign sgn_unused = sgn;

   seq_mul_addsub #(.WIDTH(WIDTH)) u_addsub (
      .hi     (acc[2*WIDTH-1:WIDTH]),
      .mcand  (mcand),
      .add_en (mult[0]),
      .sum    (sum)
   );
`endif

   // Adder MSB (carry or sign) becomes the new accumulator MSB on the shift.
   assign acc_next = {sum, acc[WIDTH-1:1]};

   // NOTE: datapath registers are reset as well, because op and the accumulator must read 0 while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         op    <= '0;
         acc   <= '0;
         cnt   <= '0;
         mcand <= '0;
         mult  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
         sgn_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments everywhere here, so every register sees pre-edge values.
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= a;
                  mult  <= b;
`ifdef SEQ_MUL_SIGNED_EN
                  sgn_q <= sgn;
`endif
                  cnt   <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               acc  <= acc_next;
               mult <= mult >> 1;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  op    <= acc_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param at WIDTH=8 and WIDTH=16 against an
// arithmetic reference product; signed cases follow SEQ_MUL_SIGNED_EN.
module tb_seq_mul_param;

`ifdef SEQ_MUL_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start8, sgn8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] op8;

   logic        start16, sgn16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] op16;

   int n_cmp = 0;
   int n_err = 0;

   seq_mul_param #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .sgn   (sgn8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .op    (op8)
   );

   seq_mul_param #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst   (rst),
      .start (start16),
      .sgn   (sgn16),
      .a     (a16),
      .b     (b16),
      .busy  (busy16),
      .done  (done16),
      .op    (op16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: integer product of the operands, reduced modulo 2^(2w).
   function automatic logic [63:0] ref_mul(input int w, input bit s,
                                           input logic [31:0] x, input logic [31:0] y);
      longint      xv, yv;
      logic [63:0] mask_in, mask_out, p;
      bit          s_eff;
      s_eff    = s & SIGNED_EN;
      mask_in  = (64'd1 << w) - 64'd1;
      mask_out = (64'd1 << (2 * w)) - 64'd1;
      xv = longint'({32'd0, x} & mask_in);
      yv = longint'({32'd0, y} & mask_in);
      if (s_eff && x[w-1]) xv = xv - longint'(64'd1 << w);
      if (s_eff && y[w-1]) yv = yv - longint'(64'd1 << w);
      p = xv * yv;
      return p & mask_out;
   endfunction

   // One 8-bit operation: checks latency, busy length, product, pulse width.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic ts, input string tag);
      logic [63:0] exp;
      int          edges, busy_cnt;
      bit          seen;
      exp = ref_mul(8, ts, {24'd0, ta}, {24'd0, tb_v});
      @(negedge clk);
      a8 = ta; b8 = tb_v; sgn8 = ts; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~sgn8;
      check({tag, "_busy_on"}, 64'(busy8), 64'd1);
      edges = 1; busy_cnt = 1; seen = 1'b0;
      while (!seen && edges < 20) begin
         @(posedge clk); #1;
         edges++;
         if (done8) seen = 1'b1;
         else if (busy8) busy_cnt++;
      end
      check({tag, "_lat"}, 64'(edges), 64'd9);
      check({tag, "_busy_len"}, 64'(busy_cnt), 64'd8);
      check({tag, "_op"}, 64'(op8), exp);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(done8), 64'd0);
      check({tag, "_op_hold"}, 64'(op8), exp);
   endtask

   initial begin
      int          e, d1, d2, n_done;
      logic [15:0] ta, tb_v;
      bit          ts, seen;
      logic [63:0] exp;

      rst = 1'b1;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1 start8 = 1'b1;
      @(posedge clk); #1;
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_done8", 64'(done8), 64'd0);
      check("rst_op8", 64'(op8), 64'd0);
      check("rst_busy16", 64'(busy16), 64'd0);
      check("rst_op16", 64'(op16), 64'd0);
      start8 = 1'b0;
      @(negedge clk) rst = 1'b0;

      run8(8'hFF, 8'hFF, 1'b0, "u_ff_ff");
      run8(8'h00, 8'h00, 1'b0, "zero");
      run8(8'h80, 8'h80, 1'b1, "s_min_min");
      run8(8'hFD, 8'h05, 1'b1, "s_m3_x5");
      run8(8'hFD, 8'h05, 1'b0, "u_fd_x5");
      run8(8'h7F, 8'h80, 1'b1, "s_max_min");
      run8(8'hFF, 8'hFF, 1'b1, "s_m1_m1");

      // Back-to-back: start held high, operands change right after accept.
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd4; sgn8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      a8 = 8'd7; b8 = 8'd9;
      e = 1; d1 = 0; d2 = 0;
      while (d2 == 0 && e < 40) begin
         @(posedge clk); #1;
         e++;
         if (d1 != 0 && e == d1 + 1) check("b2b_no_bubble", 64'(busy8), 64'd1);
         if (done8) begin
            if (d1 == 0) begin
               d1 = e;
               check("b2b_op1", 64'(op8), 64'd12);
            end else begin
               d2 = e;
               start8 = 1'b0;
               check("b2b_op2", 64'(op8), 64'd63);
            end
         end
      end
      start8 = 1'b0;
      check("b2b_lat1", 64'(d1), 64'd9);
      check("b2b_gap", 64'(d2 - d1), 64'd9);
      @(posedge clk); #1;
      check("b2b_idle", 64'(busy8), 64'd0);

      // Reset during RUN cycle 4 aborts the operation.
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd6; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_op", 64'(op8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      @(negedge clk) rst = 1'b0;
      n_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'd0);
      run8(8'd2, 8'd3, 1'b0, "after_abort");

      // Randomised 16-bit vectors with ignored start pulses during RUN.
      for (int v = 0; v < 1000; v++) begin
         case ($urandom_range(0, 7))
            0:       ta = 16'hFFFF;
            1:       ta = 16'h8000;
            2:       ta = 16'h0000;
            default: ta = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       tb_v = 16'hFFFF;
            1:       tb_v = 16'h8000;
            2:       tb_v = 16'h0000;
            default: tb_v = 16'($urandom);
         endcase
         ts  = 1'($urandom_range(0, 1));
         exp = ref_mul(16, ts, {16'd0, ta}, {16'd0, tb_v});
         @(negedge clk);
         a16 = ta; b16 = tb_v; sgn16 = ts; start16 = 1'b1;
         @(posedge clk); #1;
         start16 = 1'b0;
         e = 1; seen = 1'b0;
         while (!seen && e < 40) begin
            if (e <= 16 && $urandom_range(0, 3) == 0) begin
               start16 = 1'b1;
               a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~sgn16;
            end else begin
               start16 = 1'b0;
            end
            @(posedge clk); #1;
            e++;
            if (done16) seen = 1'b1;
         end
         start16 = 1'b0;
         check("lat16", 64'(e), 64'd17);
         check("op16", 64'(op16), exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_mul_param.md
SEQ_MUL_PARAM -- requirements
Module: seq_mul_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on clk.
REQ-005 SHALL have port sgn  input  1  1 = operands are two's-complement; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse when the product becomes valid.
REQ-010 SHALL have port op  output  2*WIDTH  product; holds its last value until the next accepted start.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: a, b and sgn are registered, the iteration counter is cleared, the accumulator is zeroed, and the FSM moves to RUN.
REQ-013 In RUN, start SHALL be ignored; operand and sgn changes SHALL NOT affect the operation in flight.
REQ-014 Each RUN cycle SHALL retire one multiplier bit, LSB first: add the multiplicand into the upper accumulator half if the bit is 1, then shift the accumulator right one place, with the adder carry or sign entering the MSB.
REQ-015 The adder SHALL be WIDTH+1 bits wide so that the carry or sign is never lost.
REQ-016 RUN SHALL last exactly WIDTH cycles; the FSM SHALL then enter DONE for one cycle, during which done=1.
REQ-017 Latency SHALL be WIDTH+1 clk edges from the edge that accepts start to the edge that asserts done.
REQ-018 op SHALL update only on the edge entering DONE, so intermediate accumulator values are never visible on op.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 DONE SHALL return to IDLE on the next edge unless start=1, in which case it goes directly to RUN (back-to-back operation, no bubble).
REQ-021 Operands of zero SHALL still take the full WIDTH cycles; there is no early termination.
REQ-022 The result SHALL be exact modulo 2^(2*WIDTH) for every operand pair, including all-ones operands and, in signed mode, the most negative value times itself.

Reset
REQ-023 While rst=1, the block SHALL be in IDLE with busy=0, done=0, op=0, and the counter and accumulator at 0, regardless of clk.
REQ-024 Assertion of rst during RUN SHALL abort the operation; no done pulse SHALL follow, and the first start after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-025 With macro SEQ_MUL_SIGNED_EN defined, sgn=1 SHALL select signed multiplication:
  - the multiplicand is sign-extended into the WIDTH+1 adder;
  - the right shift is arithmetic;
  - on the final iteration, a multiplier bit of 1 subtracts the multiplicand instead of adding it.
REQ-026 With SEQ_MUL_SIGNED_EN undefined, sgn SHALL be ignored, all operations SHALL be unsigned, and no subtract logic SHALL be synthesised.
REQ-027 The port list SHALL be identical in both builds.

Structure
REQ-028 Package seq_mul_pkg SHALL hold:
  - the FSM state enum (IDLE, RUN, DONE);
  - the counter-width function clog2(WIDTH+1);
  - the WIDTH legality bounds.
REQ-029 Sub-module seq_mul_addsub SHALL implement the (WIDTH+1)-bit add/subtract, parameterised by WIDTH; the subtract path SHALL be present only under SEQ_MUL_SIGNED_EN.
REQ-030 The FSM, counter and accumulator SHALL reside in seq_mul_param.

Verification
REQ-031 WIDTH=8, unsigned, a=8'hFF, b=8'hFF, start pulsed -> busy high for 8 cycles; done on the 9th edge; op=16'hFE01.
REQ-032 WIDTH=8, SEQ_MUL_SIGNED_EN defined, sgn=1:
  - a=8'h80, b=8'h80 -> op=16'h4000;
  - a=8'hFD (-3), b=8'h05 -> op=16'hFFF1.
REQ-033 WIDTH=8: start held high continuously, with a=3, b=4 then a=7, b=9 -> two done pulses 9 cycles apart; op=12 then op=63; no idle cycle between operations.
REQ-034 WIDTH=8: rst asserted at RUN cycle 4 of a=5, b=6 -> busy=0 and op=0 immediately; no done pulse; a subsequent a=2, b=3 gives op=6.
REQ-035 WIDTH=16: random unsigned operands (and signed operands when the macro is defined), 1000 vectors -> op matches the reference product on every done pulse; start pulses during RUN are ignored.
